// File: rtl/ch_cfg_pkg.sv
// rtl/ch_cfg_pkg.sv - shared types and constants for the channel tap-scale config sequencer
package ch_cfg_pkg;

   typedef enum logic [1:0] {
      ACCEPT = 2'd0,
      SETTLE = 2'd1,
      SWAP   = 2'd2
   } ch_cfg_state_e;

   localparam int COEF_W_DEF   = 16;
   localparam int SETTLE_W_DEF = 8;

   // Unity gain in Q2.14
   localparam logic [COEF_W_DEF-1:0] Q14_ONE = 16'h4000;

endpackage

// File: rtl/ch_cfg_settle_cnt.sv
// rtl/ch_cfg_settle_cnt.sv - loadable settle down-counter with zero flag
module ch_cfg_settle_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/channel_cfg_ctrl.sv
// rtl/channel_cfg_ctrl.sv - shadow/active tap-scale bank with settle-delayed atomic swap; CH_CFG_READBACK_EN adds shadow readback
module channel_cfg_ctrl
   import ch_cfg_pkg::*;
#(
   parameter int N_TAP    = 4,
   parameter int COEF_W   = COEF_W_DEF,
   parameter int SETTLE_W = SETTLE_W_DEF,
   parameter int IDX_W    = (N_TAP > 1) ? $clog2(N_TAP) : 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [COEF_W-1:0]       wr_data,
   input  logic                    commit_req,
   output logic                    commit_ack,
   input  logic [SETTLE_W-1:0]     settle_cyc,
   output logic [N_TAP*COEF_W-1:0] coef_active,
   output logic                    cfg_busy,
`ifdef CH_CFG_READBACK_EN
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [COEF_W-1:0]       rd_data,
`endif
   output logic                    err_idx
);

   ch_cfg_state_e     r_state;
   ch_cfg_state_e     w_state_nxt;

   logic [COEF_W-1:0] r_shadow [N_TAP];
   logic [COEF_W-1:0] r_active [N_TAP];
   logic [N_TAP-1:0]  r_dirty;
   logic              r_ack;
   logic              r_err;

   logic              w_wr_fire;
   logic              w_bad_wr;
   logic [N_TAP-1:0]  w_wr_mask;
   logic [N_TAP-1:0]  w_dirty_eff;
   logic              w_commit_go;
   logic              w_commit_empty;
   logic              w_cnt_zero;

   always_comb begin
      w_wr_mask = '0;
      for (int i = 0; i < N_TAP; i++) begin
         w_wr_mask[i] = w_wr_fire && (32'(wr_idx) == i);
      end
   end

   // A write landing in the commit cycle counts toward the dirty set being committed
   assign w_wr_fire      = wr_valid && wr_ready;
   assign w_bad_wr       = w_wr_fire && (32'(wr_idx) >= N_TAP);
   assign w_dirty_eff    = r_dirty | w_wr_mask;
   assign w_commit_go    = (r_state == ACCEPT) && commit_req && (w_dirty_eff != '0);
   assign w_commit_empty = (r_state == ACCEPT) && commit_req && (w_dirty_eff == '0);

   ch_cfg_settle_cnt #(
      .W (SETTLE_W)
   ) u_settle_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .i_load     (w_commit_go),
      .i_load_val (settle_cyc),
      .i_dec      (r_state == SETTLE),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ACCEPT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ACCEPT:  if (w_commit_go) w_state_nxt = SETTLE;
         SETTLE:  if (w_cnt_zero)  w_state_nxt = SWAP;
         SWAP:    w_state_nxt = ACCEPT;
         default: w_state_nxt = ACCEPT;
      endcase
   end

   always_comb begin
      wr_ready = 1'b0;
      cfg_busy = 1'b1;
      if (r_state == ACCEPT) begin
         wr_ready = 1'b1;
         cfg_busy = 1'b0;
      end
   end

   // A bad write seen in the ack cycle survives the clear so it is not lost
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N_TAP; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
         r_dirty <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         for (int i = 0; i < N_TAP; i++) begin
            if (w_wr_mask[i]) r_shadow[i] <= wr_data;
            if ((r_state == SWAP) && r_dirty[i]) r_active[i] <= r_shadow[i];
         end
         r_dirty <= (r_state == SWAP) ? '0 : w_dirty_eff;
         r_ack   <= (r_state == SWAP) || w_commit_empty;
         r_err   <= (r_err && !r_ack) || w_bad_wr;
      end
   end

   always_comb begin
      coef_active = '0;
      for (int i = 0; i < N_TAP; i++) begin
         coef_active[i*COEF_W +: COEF_W] = r_active[i];
      end
   end

   assign commit_ack = r_ack;
   assign err_idx    = r_err;

`ifdef CH_CFG_READBACK_EN
   logic [COEF_W-1:0] w_rd_sel;
   logic [COEF_W-1:0] r_rd_data;

   always_comb begin
      w_rd_sel = '0;
      for (int i = 0; i < N_TAP; i++) begin
         if (32'(rd_idx) == i) w_rd_sel = r_shadow[i];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_sel;
      end
   end

   assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_channel_cfg_ctrl.sv
// tb/tb_channel_cfg_ctrl.sv - self-checking bench for channel_cfg_ctrl
module tb_channel_cfg_ctrl;

   localparam int N_TAP = 4;
   localparam int COEF_W = 16;
   localparam int SETTLE_W = 8;
   localparam int IDX_W = 3;

   logic                    clk = 1'b0;
   logic                    rstn;
   logic                    wr_valid;
   logic                    wr_ready;
   logic [IDX_W-1:0]        wr_idx;
   logic [COEF_W-1:0]       wr_data;
   logic                    commit_req;
   logic                    commit_ack;
   logic [SETTLE_W-1:0]     settle_cyc;
   logic [N_TAP*COEF_W-1:0] coef_active;
   logic                    cfg_busy;
   logic                    err_idx;
`ifdef CH_CFG_READBACK_EN
   logic [IDX_W-1:0]        rd_idx = '0;
   logic [COEF_W-1:0]       rd_data;
`endif

   channel_cfg_ctrl #(
      .N_TAP    (N_TAP),
      .COEF_W   (COEF_W),
      .SETTLE_W (SETTLE_W),
      .IDX_W    (IDX_W)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_idx      (wr_idx),
      .wr_data     (wr_data),
      .commit_req  (commit_req),
      .commit_ack  (commit_ack),
      .settle_cyc  (settle_cyc),
      .coef_active (coef_active),
      .cfg_busy    (cfg_busy),
`ifdef CH_CFG_READBACK_EN
      .rd_idx      (rd_idx),
      .rd_data     (rd_data),
`endif
      .err_idx     (err_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wv;
      logic [2:0]  idx;
      logic [15:0] data;
      logic        cr;
      logic [7:0]  s;
      logic        e_ack;
      logic        e_busy;
      logic        e_ready;
      logic        e_err;
      logic [63:0] e_act;
   } vec_t;

   vec_t vec [20];
   int   n_chk = 0;
   int   n_err = 0;

   // Reference model: a commit accepted in cycle c keeps the block busy through
   // cycle c+s+2; the bank swap lands on the edge closing that cycle.
   int          m_cyc = 0;
   int          m_end = 0;
   bit          m_pend, m_ack, m_err;
   bit [3:0]    m_dirty;
   logic [15:0] m_sh [4];
   logic [15:0] m_act [4];

   function automatic logic [63:0] m_active();
      return {m_act[3], m_act[2], m_act[1], m_act[0]};
   endfunction

   task automatic model_reset();
      m_pend = 0; m_ack = 0; m_err = 0; m_dirty = '0;
      for (int i = 0; i < 4; i++) begin
         m_sh[i] = '0;
         m_act[i] = '0;
      end
   endtask

   task automatic model_step();
      bit rdy, ack_n, bad;
      rdy = !m_pend; ack_n = 0; bad = 0;
      if (rdy && wr_valid) begin
         if (int'(wr_idx) < N_TAP) begin
            m_sh[wr_idx] = wr_data;
            m_dirty[wr_idx] = 1'b1;
         end else begin
            bad = 1;
         end
      end
      if (rdy && commit_req) begin
         if (m_dirty != 0) begin
            m_pend = 1;
            m_end = m_cyc + int'(settle_cyc) + 2;
         end else begin
            ack_n = 1;
         end
      end
      if (m_pend && (m_cyc == m_end)) begin
         for (int i = 0; i < 4; i++) if (m_dirty[i]) m_act[i] = m_sh[i];
         m_dirty = '0;
         m_pend = 0;
         ack_n = 1;
      end
      m_err = (m_err && !m_ack) || bad;
      m_ack = ack_n;
      m_cyc++;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wv, input logic [2:0] idx, input logic [15:0] d,
                        input logic cr, input logic [7:0] s);
      wr_valid = wv; wr_idx = idx; wr_data = d; commit_req = cr; settle_cyc = s;
   endtask

   task automatic step_model();
      model_step();
      tick();
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_ready"}, 64'(wr_ready), 64'(!m_pend));
      chk({tag, "_busy"}, 64'(cfg_busy), 64'(m_pend));
      chk({tag, "_ack"}, 64'(commit_ack), 64'(m_ack));
      chk({tag, "_err"}, 64'(err_idx), 64'(m_err));
      chk({tag, "_active"}, coef_active, m_active());
   endtask

   function automatic vec_t mk(logic wv, logic [2:0] idx, logic [15:0] d, logic cr, logic [7:0] s,
                               logic a, logic b, logic r, logic e, logic [63:0] act);
      vec_t v;
      v.wv = wv; v.idx = idx; v.data = d; v.cr = cr; v.s = s;
      v.e_ack = a; v.e_busy = b; v.e_ready = r; v.e_err = e; v.e_act = act;
      return v;
   endfunction

   localparam logic [63:0] A1 = 64'hC000_0000_4000_0000;
   localparam logic [63:0] A2 = 64'hC000_1111_4000_0000;

   initial begin
      vec[0]  = mk(1, 3'd1, 16'h4000, 0, 8'd0, 0, 0, 1, 0, 64'h0);
      vec[1]  = mk(1, 3'd3, 16'hC000, 0, 8'd0, 0, 0, 1, 0, 64'h0);
      vec[2]  = mk(0, 3'd0, 16'h0000, 1, 8'd5, 0, 1, 0, 0, 64'h0);
      vec[3]  = mk(1, 3'd0, 16'h7777, 0, 8'd0, 0, 1, 0, 0, 64'h0);
      vec[4]  = mk(0, 3'd0, 16'h0000, 1, 8'd9, 0, 1, 0, 0, 64'h0);
      vec[5]  = mk(0, 3'd0, 16'h0000, 0, 8'd0, 0, 1, 0, 0, 64'h0);
      vec[6]  = mk(0, 3'd0, 16'h0000, 0, 8'd0, 0, 1, 0, 0, 64'h0);
      vec[7]  = mk(0, 3'd0, 16'h0000, 0, 8'd0, 0, 1, 0, 0, 64'h0);
      vec[8]  = mk(0, 3'd0, 16'h0000, 0, 8'd0, 0, 1, 0, 0, 64'h0);
      vec[9]  = mk(0, 3'd0, 16'h0000, 0, 8'd0, 1, 0, 1, 0, A1);
      vec[10] = mk(1, 3'd2, 16'h1111, 0, 8'd0, 0, 0, 1, 0, A1);
      vec[11] = mk(0, 3'd0, 16'h0000, 1, 8'd0, 0, 1, 0, 0, A1);
      vec[12] = mk(0, 3'd0, 16'h0000, 0, 8'd0, 0, 1, 0, 0, A1);
      vec[13] = mk(0, 3'd0, 16'h0000, 0, 8'd0, 1, 0, 1, 0, A2);
      vec[14] = mk(0, 3'd0, 16'h0000, 1, 8'd3, 1, 0, 1, 0, A2);
      vec[15] = mk(0, 3'd0, 16'h0000, 0, 8'd0, 0, 0, 1, 0, A2);
      vec[16] = mk(1, 3'd5, 16'hDEAD, 0, 8'd0, 0, 0, 1, 1, A2);
      vec[17] = mk(0, 3'd0, 16'h0000, 0, 8'd0, 0, 0, 1, 1, A2);
      vec[18] = mk(0, 3'd0, 16'h0000, 1, 8'd2, 1, 0, 1, 1, A2);
      vec[19] = mk(0, 3'd0, 16'h0000, 0, 8'd0, 0, 0, 1, 0, A2);

      rstn = 1'b0;
      drive(0, 3'd0, 16'h0, 0, 8'd0);
      model_reset();
      tick();
      tick();
      chk("rst_ready", 64'(wr_ready), 64'd1);
      chk("rst_busy", 64'(cfg_busy), 64'd0);
      chk("rst_ack", 64'(commit_ack), 64'd0);
      chk("rst_err", 64'(err_idx), 64'd0);
      chk("rst_active", coef_active, 64'h0);
      @(negedge clk);
      rstn = 1'b1;
      tick();

      for (int r = 0; r < 20; r++) begin
         drive(vec[r].wv, vec[r].idx, vec[r].data, vec[r].cr, vec[r].s);
         step_model();
         chk($sformatf("vec%0d_ack", r), 64'(commit_ack), 64'(vec[r].e_ack));
         chk($sformatf("vec%0d_busy", r), 64'(cfg_busy), 64'(vec[r].e_busy));
         chk($sformatf("vec%0d_ready", r), 64'(wr_ready), 64'(vec[r].e_ready));
         chk($sformatf("vec%0d_err", r), 64'(err_idx), 64'(vec[r].e_err));
         chk($sformatf("vec%0d_active", r), coef_active, vec[r].e_act);
      end

      // settle_cyc=0 with a write in the commit cycle: ack on the third cycle
      drive(1, 3'd0, 16'h1234, 1, 8'd0);
      step_model();
      drive(0, 3'd0, 16'h0, 0, 8'd0);
      chk("s0_c1_ack", 64'(commit_ack), 64'd0);
      chk("s0_c1_busy", 64'(cfg_busy), 64'd1);
      step_model();
      chk("s0_c2_ack", 64'(commit_ack), 64'd0);
      chk("s0_c2_active", coef_active, A2);
      step_model();
      chk("s0_c3_ack", 64'(commit_ack), 64'd1);
      chk("s0_c3_active", coef_active, 64'hC000_1111_4000_1234);
      step_model();
      chk("s0_c4_ack", 64'(commit_ack), 64'd0);

      // Reset mid-SETTLE with counter at 3
      drive(1, 3'd2, 16'h2222, 1, 8'd5);
      step_model();
      drive(0, 3'd0, 16'h0, 0, 8'd0);
      step_model();
      step_model();
      chk("mid_busy", 64'(cfg_busy), 64'd1);
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      chk("arst_busy", 64'(cfg_busy), 64'd0);
      chk("arst_ready", 64'(wr_ready), 64'd1);
      chk("arst_active", coef_active, 64'h0);
      chk("arst_ack", 64'(commit_ack), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      tick();
      for (int k = 0; k < 12; k++) begin
         step_model();
         chk($sformatf("post_rst%0d_ack", k), 64'(commit_ack), 64'd0);
         chk($sformatf("post_rst%0d_active", k), coef_active, 64'h0);
      end

      for (int k = 0; k < 500; k++) begin
         drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
               1'($urandom_range(0, 5) == 0), 8'($urandom_range(0, 6)));
         step_model();
         chk_model($sformatf("rnd%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/channel_cfg_ctrl.md
Name: channel_cfg_ctrl

Overview:
Configuration sequencer for the reduced-order channel model's tap scale vector (N summed filter branches).
- Accepts per-tap coefficient writes over a valid/ready port into a shadow bank.
- On commit, waits a programmable settle interval (covers the channel's flight delay), then atomically swaps dirty taps into the active bank.
- The active bank drives the adder's scale inputs, so the channel never sees a partially updated coefficient set.

Parameters:
N_TAP, 4, number of filter branches / scale coefficients
COEF_W, 16, coefficient width (signed, Q2.14)
SETTLE_W, 8, width of settle-cycle count
IDX_W, $clog2(N_TAP) (min 1), tap index width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
wr_valid  in  1  coefficient write request
wr_ready  out  1  write accept
wr_idx  in  IDX_W  target tap
wr_data  in  COEF_W  coefficient value
commit_req  in  1  request swap shadow->active
commit_ack  out  1  one-cycle pulse, swap done
settle_cyc  in  SETTLE_W  settle cycles before swap, sampled at commit accept
coef_active  out  N_TAP*COEF_W  active coefficients, tap0 in LSBs
cfg_busy  out  1  high in SETTLE/SWAP
err_idx  out  1  sticky: write with wr_idx>=N_TAP seen

Behaviour:
- States ACCEPT, SETTLE, SWAP.
- Reset (async, any state): state=ACCEPT; shadow, active and dirty mask all zero; counter=0; outputs coef_active=0, commit_ack=0, cfg_busy=0, err_idx=0, wr_ready=1.
- ACCEPT: wr_ready=1.
  - wr_valid&&wr_ready: shadow[wr_idx]<=wr_data, dirty[wr_idx]<=1.
  - Repeated writes to the same tap: last wins.
- Out-of-range idx: handshake completes, data dropped, dirty unchanged, err_idx<=1. err_idx clears only on a commit_ack cycle or reset.
- commit_req in ACCEPT with dirty!=0:
  - load counter<=settle_cyc; go to SETTLE.
  - A write accepted the same cycle is included in the commit.
- commit_req in ACCEPT with dirty==0: no swap; commit_ack=1 next cycle; stay in ACCEPT.
- SETTLE: wr_ready=0, cfg_busy=1.
  - counter==0 -> SWAP; else counter decrements.
  - commit_req ignored.
- SWAP, single cycle: for each dirty tap, active<=shadow; dirty<=0; then ACCEPT.
- commit_ack is registered: high exactly one cycle, the cycle after SWAP. Clean taps are never rewritten.
- Latency, commit_req sampled to commit_ack high: settle_cyc+3 cycles (settle_cyc=0 -> 3).
- commit_req held high after ack: treated as a new request; requester deasserts on ack.
- coef_active changes only on the SWAP edge; glitch-free register outputs.

Optional Feature:
CH_CFG_READBACK_EN
- Defined: adds rd_idx (in, IDX_W) and rd_data (out, COEF_W).
  - rd_data registered, 1-cycle latency, returns shadow[rd_idx].
  - Out-of-range returns 0.
  - Resets to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package ch_cfg_pkg: state enum (ACCEPT=0, SETTLE=1, SWAP=2), default COEF_W/SETTLE_W constants, Q2.14 unity constant.
- One sub-module ch_cfg_settle_cnt: loadable down-counter with zero flag, async active-low reset.

Test Plan:
- Reset, then write tap1=0x4000, tap3=0xC000, commit with settle_cyc=5 -> coef_active tap1/tap3 update on the same edge; commit_ack exactly 8 cycles after commit_req; taps 0/2 stay 0.
- During SETTLE, drive wr_valid -> wr_ready=0 with no shadow change. Write accepted after ack -> applied on the next commit only.
- Commit with no dirty taps -> commit_ack 1 cycle later; coef_active unchanged; cfg_busy stays 0.
- wr_idx=5 with N_TAP=4 -> handshake completes, err_idx=1, no dirty bit. Next commit_ack clears err_idx.
- Assert rstn low mid-SETTLE (counter=3) -> immediate ACCEPT, coef_active=0, no commit_ack after release.
- settle_cyc=0 with simultaneous write(tap0=0x1234) and commit_req -> tap0 active=0x1234, commit_ack 3 cycles later.
